shift_feeder: RTL and testbench

Upstream feeder for the 4-bit serial shift register stage. Accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and serializes each word MSB-first onto a single bit line together with a shift-enable strobe. After WIDTH enabled shifts the downstream register holds the word exactly. A programmable idle gap can be inserted between words.

---
 rtl/shift_feeder_pkg.sv | 29 ++
 rtl/shift_feeder_if.sv | 19 +
 rtl/feeder_fifo.sv | 69 ++++++
 rtl/shift_feeder.sv | 196 +++++++++++++++++++
 tb/tb_shift_feeder.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_feeder_pkg.sv
// -----------------------------------------------------------------------------
// shift_feeder_pkg
// Shared types and defaults for the serial shift-register feeder.
//   state_t            : feeder FSM states (IDLE, SHIFT, GAP)
//   *_DEFAULT          : default parameter values for the feeder and its FIFO
//   cnt_width()        : counter width for a count range, never below 1 bit
// -----------------------------------------------------------------------------
package shift_feeder_pkg;

    localparam int WIDTH_DEFAULT      = 4;
    localparam int FIFO_DEPTH_DEFAULT = 2;
    localparam int GAP_CYCLES_DEFAULT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // $clog2(n) collapses to 0 for n <= 1; a zero-width counter is not legal.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/shift_feeder_if.sv
// -----------------------------------------------------------------------------
// shift_feeder_if
// Parallel word handshake into the feeder.
//   in_valid : master -> slave, in_data holds a word
//   in_ready : slave  -> master, word is taken at the rising edge if valid
//   in_data  : master -> slave, parallel word (WIDTH bits)
// -----------------------------------------------------------------------------
interface shift_feeder_if
    import shift_feeder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/feeder_fifo.sv
// -----------------------------------------------------------------------------
// feeder_fifo
// Synchronous FIFO buffering parallel words ahead of the serializer.
//   clk, reset : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write wdata at the rising edge (ignored when full)
//   pop/rdata  : rdata shows the head entry; pop drops it (ignored when empty)
//   count      : number of stored entries, full / empty flags
// -----------------------------------------------------------------------------
module feeder_fifo
    import shift_feeder_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(FIFO_DEPTH));
    assign empty  = (r_count == (AW+1)'(0));
    assign count  = r_count;
    assign rdata  = r_mem[r_rptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage write; payload needs no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= AW'(0);
            r_rptr  <= AW'(0);
            r_count <= (AW+1)'(0);
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/shift_feeder.sv
// -----------------------------------------------------------------------------
// shift_feeder
// Accepts parallel words, buffers them, and serializes each word MSB-first
// with a shift-enable strobe for a downstream serial shift register. An
// optional idle gap of GAP_CYCLES cycles separates consecutive words.
//   clk, reset : clock, asynchronous active-low reset
//   s_if       : word handshake (in_valid / in_ready / in_data)
//   ser_bit    : serial data, 0 whenever shift_en is low
//   shift_en   : downstream shift strobe
//   word_done  : pulse on the last shift cycle of each word
//   busy       : FSM not idle or FIFO non-empty
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module shift_feeder
    import shift_feeder_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    shift_feeder_if.slave s_if,
    output logic          ser_bit,
    output logic          shift_en,
    output logic          word_done,
    output logic          busy
);
    localparam int BW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] w_word_nx;
    logic [BW-1:0]    r_bit_cnt;
    logic [BW-1:0]    w_bit_nx;
    logic [GW-1:0]    r_gap_cnt;
    logic [GW-1:0]    w_gap_nx;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_rdata;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_count_nx;
    logic             w_full;
    logic             w_empty;
    logic [BW-1:0]    w_bit_idx;

    logic             r_in_ready;
    logic             r_ser_bit;
    logic             r_shift_en;
    logic             r_word_done;
    logic             r_busy;
    logic             w_in_ready_d;
    logic             w_ser_bit_d;
    logic             w_shift_en_d;
    logic             w_word_done_d;
    logic             w_busy_d;

    // r_in_ready already implies room; the full term keeps the FIFO safe anyway.
    assign w_push     = s_if.in_valid && r_in_ready && !w_full;
    assign w_count_nx = w_count + CW'(w_push) - CW'(w_pop);

    feeder_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (s_if.in_data),
        .rdata (w_rdata),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // FSM state register plus word register and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_word    <= WIDTH'(0);
            r_bit_cnt <= BW'(0);
            r_gap_cnt <= GW'(0);
        end else begin
            r_state   <= w_state_nx;
            r_word    <= w_word_nx;
            r_bit_cnt <= w_bit_nx;
            r_gap_cnt <= w_gap_nx;
        end
    end

    // Next-state logic; decides pops and loads the next word without a bubble.
    always_comb begin
        w_state_nx = r_state;
        w_word_nx  = r_word;
        w_bit_nx   = r_bit_cnt;
        w_gap_nx   = r_gap_cnt;
        w_pop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_bit_nx = BW'(0);
                w_gap_nx = GW'(0);
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_word_nx  = w_rdata;
                    w_state_nx = ST_SHIFT;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_bit_nx = BW'(0);
                    w_gap_nx = GW'(0);
                    if (GAP_CYCLES > 0) begin
                        w_state_nx = ST_GAP;
                    end else if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_word_nx  = w_rdata;
                        w_state_nx = ST_SHIFT;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_bit_nx = r_bit_cnt + BW'(1);
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_nx = GW'(0);
                    w_bit_nx = BW'(0);
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_word_nx  = w_rdata;
                        w_state_nx = ST_SHIFT;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_gap_nx = r_gap_cnt + GW'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_bit_nx   = BW'(0);
                w_gap_nx   = GW'(0);
            end
        endcase
    end

    // Output decode from the next state, so the flops below show the
    // values belonging to the state the FSM is entering.
    always_comb begin
        w_bit_idx     = BIT_LAST - w_bit_nx;
        w_shift_en_d  = (w_state_nx == ST_SHIFT);
        w_in_ready_d  = (w_count_nx < CW'(FIFO_DEPTH));
        w_busy_d      = (w_state_nx != ST_IDLE) || (w_count_nx != CW'(0));
        if (w_shift_en_d) begin
            w_ser_bit_d   = w_word_nx[w_bit_idx];
            w_word_done_d = (w_bit_nx == BIT_LAST);
        end else begin
            w_ser_bit_d   = 1'b0;
            w_word_done_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready  <= 1'b0;
            r_ser_bit   <= 1'b0;
            r_shift_en  <= 1'b0;
            r_word_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_d;
            r_ser_bit   <= w_ser_bit_d;
            r_shift_en  <= w_shift_en_d;
            r_word_done <= w_word_done_d;
            r_busy      <= w_busy_d;
        end
    end

    assign s_if.in_ready = r_in_ready;
    assign ser_bit       = r_ser_bit;
    assign shift_en      = r_shift_en;
    assign word_done     = r_word_done;
    assign busy          = r_busy;

endmodule

// File: tb/tb_shift_feeder.sv
// -----------------------------------------------------------------------------
// tb_shift_feeder
// Directed bench for shift_feeder: dut0 uses GAP_CYCLES = 0, dut2 uses
// GAP_CYCLES = 2. A per-cycle vector table covers a single word and a
// back-to-back burst; hand sequences cover gap, backpressure and mid-word reset.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_shift_feeder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_feeder_if #(.WIDTH(4)) if0 ();
    shift_feeder_if #(.WIDTH(4)) if2 ();

    logic sb0, se0, wd0, by0;
    logic sb2, se2, wd2, by2;

    shift_feeder #(.WIDTH(4), .FIFO_DEPTH(2), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .s_if(if0.slave),
        .ser_bit(sb0), .shift_en(se0), .word_done(wd0), .busy(by0)
    );

    shift_feeder #(.WIDTH(4), .FIFO_DEPTH(2), .GAP_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .s_if(if2.slave),
        .ser_bit(sb2), .shift_en(se2), .word_done(wd2), .busy(by2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Downstream shift-register models and words seen at each word_done.
    logic [3:0] rx0 = 4'd0;
    logic [3:0] rx2 = 4'd0;
    logic [3:0] q0[$];
    logic [3:0] q2[$];

    typedef struct packed {
        logic       vld;
        logic [3:0] data;
        logic       rdy;
        logic       sen;
        logic       sbit;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Close the current cycle: update downstream models, advance to the next cycle.
    task automatic tick();
        if (se0 === 1'b1) rx0 = {rx0[2:0], sb0};
        if (wd0 === 1'b1) q0.push_back(rx0);
        if (se2 === 1'b1) rx2 = {rx2[2:0], sb2};
        if (wd2 === 1'b1) q2.push_back(rx2);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] d, input logic r,
                                input logic s, input logic b, input logic dn, input logic by);
        vec_t t;
        t.vld = v; t.data = d; t.rdy = r; t.sen = s; t.sbit = b; t.done = dn; t.busy = by;
        return t;
    endfunction

    logic [12:0] pat_sen, pat_bit, pat_done;
    logic [3:0]  bp_w [4];

    initial begin
        int idx, acc_cyc, stalls, sen_cnt, gap_len, hi_sen, hi_busy;
        logic seen_done, gap_closed;

        // single word 1011, then burst A,5,F (dut0, no gap)
        tbl[0]  = mk(1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[2]  = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl[5]  = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tbl[6]  = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tbl[9]  = mk(1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[11] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl[12] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tbl[13] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[14] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl[15] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[16] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tbl[17] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl[18] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl[19] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl[20] = mk(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tbl[21] = mk(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        pat_sen  = 13'b0001111001111;
        pat_bit  = 13'b0000011001100;
        pat_done = 13'b0001000001000;
        bp_w[0] = 4'h6; bp_w[1] = 4'h9; bp_w[2] = 4'hE; bp_w[3] = 4'h7;

        // ---------------- reset with in_valid held high ----------------
        reset = 1'b1;
        if0.in_valid = 1'b1; if0.in_data = 4'hF;
        if2.in_valid = 1'b1; if2.in_data = 4'hF;
        #2 reset = 1'b0;
        repeat (3) tick();
        check("rst_in_ready0", if0.in_ready, 1'b0);
        check("rst_ser_bit0", sb0, 1'b0);
        check("rst_shift_en0", se0, 1'b0);
        check("rst_word_done0", wd0, 1'b0);
        check("rst_busy0", by0, 1'b0);
        check("rst_in_ready2", if2.in_ready, 1'b0);
        reset = 1'b1;
        if0.in_valid = 1'b0; if2.in_valid = 1'b0;
        if0.in_data = 4'h0; if2.in_data = 4'h0;
        check("rdy_at_release", if0.in_ready, 1'b0);
        tick();

        // ---------------- vector table on dut0 ----------------
        for (int i = 0; i < 22; i++) begin
            check($sformatf("tbl%0d_rdy", i), if0.in_ready, tbl[i].rdy);
            check($sformatf("tbl%0d_sen", i), se0, tbl[i].sen);
            check($sformatf("tbl%0d_bit", i), sb0, tbl[i].sbit);
            check($sformatf("tbl%0d_done", i), wd0, tbl[i].done);
            check($sformatf("tbl%0d_busy", i), by0, tbl[i].busy);
            if (i == 6)  check("ds_after_B", rx0, 4'hB);
            if (i == 21) check("ds_after_F", rx0, 4'hF);
            if0.in_valid = tbl[i].vld;
            if0.in_data  = tbl[i].data;
            tick();
        end
        check("tbl_word_count", q0.size(), 4);
        if (q0.size() == 4) begin
            check("tbl_word0", q0[0], 4'hB);
            check("tbl_word1", q0[1], 4'hA);
            check("tbl_word2", q0[2], 4'h5);
            check("tbl_word3", q0[3], 4'hF);
        end

        // ---------------- gap of 2 on dut2: words 3 then C ----------------
        check("gap_rdy_w0", if2.in_ready, 1'b1);
        if2.in_valid = 1'b1; if2.in_data = 4'h3;
        tick();
        check("gap_rdy_w1", if2.in_ready, 1'b1);
        if2.in_data = 4'hC;
        tick();
        if2.in_valid = 1'b0; if2.in_data = 4'h0;
        seen_done = 1'b0; gap_closed = 1'b0; gap_len = 0;
        for (int k = 0; k < 13; k++) begin
            check($sformatf("gap%0d_sen", k), se2, pat_sen[k]);
            check($sformatf("gap%0d_bit", k), sb2, pat_bit[k]);
            check($sformatf("gap%0d_done", k), wd2, pat_done[k]);
            if (seen_done && !gap_closed) begin
                if (se2) gap_closed = 1'b1;
                else     gap_len++;
            end
            if (wd2) seen_done = 1'b1;
            tick();
        end
        check("gap_len", gap_len, 2);
        check("gap_busy_end", by2, 1'b0);
        check("gap_word_count", q2.size(), 2);
        if (q2.size() == 2) begin
            check("gap_word0", q2[0], 4'h3);
            check("gap_word1", q2[1], 4'hC);
        end

        // ---------------- backpressure on dut0: 6 shifting, 9,E,7 behind ----------------
        q0.delete();
        idx = 0; acc_cyc = -1; stalls = 0; sen_cnt = 0;
        for (int c = 0; c < 60 && q0.size() < 4; c++) begin
            if (idx < 4) begin
                if0.in_valid = 1'b1;
                if0.in_data  = bp_w[idx];
            end else begin
                if0.in_valid = 1'b0;
                if0.in_data  = 4'h0;
            end
            if (se0) sen_cnt++;
            if (if0.in_valid && if0.in_ready) begin
                if (idx == 3) acc_cyc = c;
                idx++;
            end else if (if0.in_valid) begin
                stalls++;
            end
            tick();
        end
        if0.in_valid = 1'b0;
        check("bp_word_count", q0.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q0.size()) check($sformatf("bp_word%0d", i), q0[i], bp_w[i]);
        end
        check("bp_last_accept_cycle", acc_cyc, 6);
        check("bp_stall_cycles", stalls, 3);
        check("bp_shift_cycles", sen_cnt, 16);

        // ---------------- reset after 2 bits of 9, word 6 queued ----------------
        q0.delete();
        if0.in_valid = 1'b1; if0.in_data = 4'h9;
        tick();
        if0.in_data = 4'h6;
        tick();
        if0.in_valid = 1'b0; if0.in_data = 4'h0;
        check("mid_sen_b0", se0, 1'b1);
        check("mid_bit_b0", sb0, 1'b1);
        tick();
        check("mid_bit_b1", sb0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", if0.in_ready, 1'b0);
        check("mid_rst_ser_bit", sb0, 1'b0);
        check("mid_rst_shift_en", se0, 1'b0);
        check("mid_rst_word_done", wd0, 1'b0);
        check("mid_rst_busy", by0, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        hi_sen = 0; hi_busy = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (se0) hi_sen++;
            if (by0) hi_busy++;
        end
        check("post_rst_shift_cycles", hi_sen, 0);
        check("post_rst_busy_cycles", hi_busy, 0);
        check("post_rst_word_count", q0.size(), 0);
        check("post_rst_rdy", if0.in_ready, 1'b1);
        if0.in_valid = 1'b1; if0.in_data = 4'h5;
        tick();
        if0.in_valid = 1'b0; if0.in_data = 4'h0;
        for (int c = 0; c < 20 && q0.size() < 1; c++) tick();
        repeat (8) tick();
        check("post_rst_new_count", q0.size(), 1);
        if (q0.size() >= 1) check("post_rst_new_word", q0[0], 4'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
